// File: rtl/number_to_ascii6digit_pkg.sv
// Shared constants and types for the binary <-> ASCII decimal converters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package number_to_ascii6digit_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SEND
  } state_t;

  // Largest value representable in num_digits decimal digits (10**n - 1).
  function automatic longint unsigned max_value(input int num_digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < num_digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 to every BCD nibble >= 5, then shift left taking bit_in.
// Latency: combinational.
// Backpressure: none.
module bcd_dabble_step #(
  parameter int NUM_DIGITS = 6
) (
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bit_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  logic       carry;
  logic [3:0] adj;

  // Correct each nibble, then place its low three bits one position up; the
  // nibble's MSB ripples into the next digit's LSB. The top digit's MSB falls
  // off, which only happens for inputs the caller flags as overflow.
  always_comb begin
    bcd_out = '0;
    carry   = bit_in;
    adj     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj = bcd_in[4*i +: 4];
      if (adj >= 4'd5) begin
        adj = adj + 4'd3;
      end
      bcd_out[4*i]       = carry;
      bcd_out[4*i+1 +: 3] = adj[2:0];
      carry              = adj[3];
    end
  end

endmodule

// File: rtl/number_to_ascii6digit.sv
// Binary to NUM_DIGITS ASCII decimal digits, parallel result plus MSD-first byte stream.
// Latency: accept to ascii_vld/first out_valid = IN_WIDTH+1 cycles; one byte per handshake.
// Backpressure: out_ready low holds out_byte/out_last; in_ready low until the last byte leaves.
module number_to_ascii6digit
  import number_to_ascii6digit_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     number,
  output logic [8*NUM_DIGITS-1:0] ascii,
  output logic                    ascii_vld,
  output logic                    overflow,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int              CNT_W   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int              DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int              BCD_W   = 4 * NUM_DIGITS;
  localparam longint unsigned MAX_NUM = max_value(NUM_DIGITS);

  state_t                  state;
  logic [IN_WIDTH-1:0]     shift;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DIG_W-1:0]        dig;
  logic [DIG_W-1:0]        dig_dec;
  logic [8*NUM_DIGITS-1:0] ascii_next;

  bcd_dabble_step #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_step (
    .bcd_in (bcd),
    .bit_in (shift[IN_WIDTH-1]),
    .bcd_out(bcd_next)
  );

  assign dig_dec = dig - 1'b1;

  // ASCII image of the BCD value after the final shift; saturates on overflow.
  always_comb begin
    ascii_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ascii_next[8*i +: 8] = overflow ? ASCII_NINE
                                      : (ASCII_ZERO + {4'h0, bcd_next[4*i +: 4]});
    end
  end

  // Control FSM: accept, IN_WIDTH shift-add-3 cycles, then serialize MSD first.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      ascii     <= '0;
      ascii_vld <= 1'b0;
      overflow  <= 1'b0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      shift     <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      dig       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift     <= number;
            bcd       <= '0;
            bit_cnt   <= '0;
            overflow  <= (64'(number) > MAX_NUM);
            ascii_vld <= 1'b0;
            in_ready  <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shift   <= shift << 1;
          bcd     <= bcd_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(IN_WIDTH - 1)) begin
            bit_cnt   <= '0;
            ascii     <= ascii_next;
            ascii_vld <= 1'b1;
            out_byte  <= ascii_next[8*(NUM_DIGITS-1) +: 8];
            out_valid <= 1'b1;
            out_last  <= (NUM_DIGITS == 1);
            dig       <= DIG_W'(NUM_DIGITS - 1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              dig      <= dig_dec;
              out_byte <= ascii[{dig_dec, 3'b000} +: 8];
              out_last <= (dig_dec == '0);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_number_to_ascii6digit.sv
// Directed bench for number_to_ascii6digit: conversion values, stream order, backpressure,
// mid-conversion reset and back-to-back accepts. Inputs driven and outputs sampled on negedge.
module tb_number_to_ascii6digit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] number = '0;
  logic [47:0] ascii;
  logic        ascii_vld;
  logic        overflow;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  int checks = 0;
  int passed = 0;

  number_to_ascii6digit #(.IN_WIDTH(32), .NUM_DIGITS(6)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .number   (number),
    .ascii    (ascii),
    .ascii_vld(ascii_vld),
    .overflow (overflow),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  // Present v, wait for the accept edge, then count edges (accept edge included) to ascii_vld.
  task automatic start(input logic [31:0] v, output int lat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    number   = v;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!ascii_vld && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Drain six bytes with out_ready high; returns bytes MSB-first and the out_last pattern.
  task automatic collect(output logic [47:0] got, output logic [5:0] lasts, output bit ok);
    int w;
    out_ready = 1'b1;
    got   = '0;
    lasts = '0;
    ok    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!out_valid && w < 50) begin
        @(negedge clock);
        w++;
      end
      if (!out_valid) begin
        ok = 1'b0;
        break;
      end
      got   = {got[39:0], out_byte};
      lasts = {lasts[4:0], out_last};
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({in_ready, ascii_vld, overflow, out_valid, out_last} !== 5'b10000)
      $display("FAIL reset_flags: got %b want 10000",
               {in_ready, ascii_vld, overflow, out_valid, out_last});
    else passed++;
    checks++;
    if ({ascii, out_byte} !== 56'h0)
      $display("FAIL reset_data: got %h want 0", {ascii, out_byte});
    else passed++;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_value(input logic [31:0] v, input logic [47:0] exp,
                            input logic exp_ovf, input string name);
    int         lat;
    bit         ok;
    logic [47:0] got;
    logic [5:0]  lasts;
    start(v, lat, ok);
    checks++;
    if (!ok || lat != 33) $display("FAIL %s latency: got %0d (ready %0b) want 33", name, lat, ok);
    else passed++;
    checks++;
    if (ascii !== exp || overflow !== exp_ovf)
      $display("FAIL %s parallel: got %h ovf %b want %h ovf %b", name, ascii, overflow, exp, exp_ovf);
    else passed++;
    collect(got, lasts, ok);
    checks++;
    if (!ok || got !== exp) $display("FAIL %s stream: got %h want %h", name, got, exp);
    else passed++;
    checks++;
    if (lasts !== 6'b000001) $display("FAIL %s last: got %b want 000001", name, lasts);
    else passed++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ascii !== exp || ascii_vld !== 1'b1)
      $display("FAIL %s after: got vld %b rdy %b ascii %h avld %b want 0 1 %h 1",
               name, out_valid, in_ready, ascii, ascii_vld, exp);
    else passed++;
  endtask

  task automatic test_backpressure();
    int          lat;
    int          w;
    int          held_bad;
    bit          ok;
    logic [47:0] got;
    start(32'd123456, lat, ok);
    out_ready = 1'b1;
    got = '0;
    held_bad = 0;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!out_valid && w < 50) begin
        @(negedge clock);
        w++;
      end
      if (k == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          if (out_valid !== 1'b1 || out_byte !== 8'h34) held_bad++;
        end
        out_ready = 1'b1;
      end
      got = {got[39:0], out_byte};
      @(negedge clock);
    end
    checks++;
    if (held_bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", held_bad);
    else passed++;
    checks++;
    if (got !== 48'h313233343536) $display("FAIL bp_stream: got %h want 313233343536", got);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int stray;
    wait (in_ready === 1'b1);
    @(negedge clock);
    number   = 32'd1234567;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if ({in_ready, ascii_vld, overflow, out_valid, out_last, out_byte, ascii} !== {5'b10000, 56'h0})
      $display("FAIL rst_mid: got %b %h %h want 10000 0 0",
               {in_ready, ascii_vld, overflow, out_valid, out_last}, out_byte, ascii);
    else passed++;
    @(negedge clock);
    resetn = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || ascii_vld !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL rst_stray: got %0d cycles with output want 0", stray);
    else passed++;
    test_value(32'd42, 48'h303030303432, 1'b0, "after_reset_42");
  endtask

  task automatic test_back_to_back();
    int          w;
    bit          ok;
    logic [47:0] got;
    logic [5:0]  lasts;
    number   = 32'd111111;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    number = 32'd222222;
    w = 0;
    while (!ascii_vld && w < 100) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (ascii !== 48'h313131313131) $display("FAIL b2b_first: got %h want 313131313131", ascii);
    else passed++;
    collect(got, lasts, ok);
    checks++;
    if (!ok || got !== 48'h313131313131) $display("FAIL b2b_stream1: got %h want 313131313131", got);
    else passed++;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_idle: got rdy %b vld %b want 1 0", in_ready, out_valid);
    else passed++;
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || ascii_vld !== 1'b0)
      $display("FAIL b2b_accept: got rdy %b avld %b want 0 0", in_ready, ascii_vld);
    else passed++;
    w = 0;
    while (!ascii_vld && w < 100) begin
      @(negedge clock);
      w++;
    end
    collect(got, lasts, ok);
    checks++;
    if (!ok || got !== 48'h323232323232 || lasts !== 6'b000001)
      $display("FAIL b2b_stream2: got %h last %b want 323232323232 000001", got, lasts);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_value(32'd123456,     48'h313233343536, 1'b0, "v123456");
    test_value(32'd0,          48'h303030303030, 1'b0, "v0");
    test_value(32'd999999,     48'h393939393939, 1'b0, "v999999");
    test_value(32'd1000000,    48'h393939393939, 1'b1, "v1000000");
    test_value(32'hFFFF_FFFF,  48'h393939393939, 1'b1, "vmax32");
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
